uart_cmd_bridge: RTL and testbench
==================================

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameter TIMEOUT, default 1000, meaning the maximum number of clk cycles between bytes of one command frame; the value SHALL be at least 1.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_received  input  1  one-cycle pulse from the UART: a byte is valid on rx_byte.
REQ-005 rx_byte  input  8  received byte, valid when rx_received=1.
REQ-006 rx_error  input  1  UART framing-error pulse.
REQ-007 tx_busy  input  1  UART is transmitting; this port connects to the UART is_transmitting output.
REQ-008 tx_transmit  output  1  one-cycle request to the UART to send tx_data.
REQ-009 tx_data  output  8  byte to send, valid when tx_transmit=1.
REQ-010 bus_req  output  1  bus request, held high until bus_ack is sampled.
REQ-011 bus_we  output  1  1=write, 0=read; stable while bus_req=1.
REQ-012 bus_addr  output  8  word address; stable while bus_req=1.
REQ-013 bus_wdata  output  32  write data; stable while bus_req=1.
REQ-014 bus_ack  input  1  bus completion, sampled only while bus_req=1.
REQ-015 bus_rdata  input  32  read data, valid on the bus_ack cycle of a read.

Function
REQ-016 Frame format SHALL be one of the following:
- 0x57 ('W'), then addr, then d0, d1, d2, d3, where d0 is the LSB.
- 0x52 ('R'), then addr.
REQ-017 The responses SHALL be as follows:
- A write SHALL return 0x4B ('K').
- A read SHALL return rdata[7:0], [15:8], [23:16], [31:24] in that order.
- Any other command byte SHALL return 0x45 ('E').
REQ-018 The FSM SHALL have the states IDLE, GET_ADDR, GET_DATA, BUS, SEND, WAIT_HI and WAIT_LO.
REQ-019 IDLE, on rx_received, SHALL take the following transitions:
- On 'W' or 'R', latch the opcode and go to GET_ADDR.
- On any other byte, load 0x45 as a 1-byte response and go to SEND.
REQ-020 GET_ADDR, on rx_received, SHALL latch bus_addr and then:
- For a write, clear the byte index and go to GET_DATA.
- For a read, go to BUS.
REQ-021 GET_DATA, on each rx_received, SHALL store the byte into bus_wdata[8*idx+7:8*idx] and increment the 2-bit idx; after the 4th byte it SHALL go to BUS.
REQ-022 bus_req SHALL assert in the first cycle in BUS.
REQ-023 On the cycle bus_ack=1, bus_req SHALL deassert the next cycle, and the FSM SHALL load the response and go to SEND; the response is 0x4B for a write, or the 4 bus_rdata bytes for a read, which SHALL be latched on the ack cycle.
REQ-024 BUS SHALL wait indefinitely for bus_ack, with no timeout.
REQ-025 SEND, when tx_busy=0, SHALL pulse tx_transmit for exactly one cycle with the current response byte on tx_data, then go to WAIT_HI.
REQ-026 WAIT_HI SHALL wait for tx_busy=1; WAIT_LO SHALL then wait for tx_busy=0.
REQ-027 After WAIT_LO, the FSM SHALL return to SEND if response bytes remain, otherwise to IDLE.
REQ-028 tx_transmit SHALL never assert twice without an intervening tx_busy high-then-low sequence.
REQ-029 The timeout counter (16 bits, saturating) SHALL clear on entry to GET_ADDR or GET_DATA and on every rx_received.
REQ-030 When the timeout counter reaches TIMEOUT in GET_ADDR or GET_DATA, the frame SHALL be discarded and the FSM SHALL return to IDLE with no response and no bus access.
REQ-031 rx_error in GET_ADDR or GET_DATA SHALL discard the frame and return the FSM to IDLE with no response.
REQ-032 rx_error in IDLE SHALL be ignored.
REQ-033 rx_received or rx_error while in BUS, SEND, WAIT_HI or WAIT_LO SHALL be ignored, and the byte SHALL be dropped.
REQ-034 If rx_received and rx_error occur in the same cycle, rx_error SHALL take priority.
REQ-035 If rx_received coincides with the timeout cycle, the byte SHALL be accepted and the counter cleared.
REQ-036 bus_wdata and bus_addr SHALL hold their last values outside BUS.

Reset
REQ-037 While rst=1, the FSM SHALL go to IDLE, and tx_transmit, bus_req, bus_we, tx_data, bus_addr, bus_wdata, idx and the timeout counter SHALL be 0.
REQ-038 Reset SHALL take effect in any state, including mid-frame, mid-bus-cycle (bus_req drops the next cycle) and mid-response; the remaining response bytes SHALL be discarded.

Verification
REQ-039 The bench SHALL cover the following directed scenarios:
- Write: bytes 57,10,EF,BE,AD,DE with ack 3 cycles later -> one bus_req with we=1, addr=0x10, wdata=0xDEADBEEF; then exactly one tx_transmit with 0x4B.
- Read: bytes 52,22 with ack carrying rdata=0x12345678 -> bus_req with we=0, addr=0x22; tx bytes 78,56,34,12 in order, each sent only after tx_busy rises and falls.
- Bad command and errors: byte 0x41 -> tx 0x45 with no bus_req; 57,10,AA then rx_error -> no bus_req, no tx; next frame 52,01 served normally.
- Timeout: with TIMEOUT=20, 52 then silence for 20 cycles -> return to IDLE with no bus_req; late byte 0x01 treated as a new command -> tx 0x45.
- Reset and busy-time traffic: rst pulsed while bus_req=1 -> bus_req=0 the next cycle and no response; bytes arriving during SEND/WAIT are dropped and the response is unchanged.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART command frames ('W' addr d0..d3 / 'R' addr) bridged to a single-word register bus
`timescale 1ns/1ps
module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_received,
  input  logic [7:0]  rx_byte,
  input  logic        rx_error,
  input  logic        tx_busy,
  output logic        tx_transmit,
  output logic [7:0]  tx_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] tmo_cnt;
  logic [31:0] resp;
  logic [2:0]  resp_left;
  logic        timed_out;

  assign timed_out = (32'(tmo_cnt) >= TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_transmit <= 1'b0;
      tx_data     <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      resp        <= '0;
      resp_left   <= '0;
    end else begin
      tx_transmit <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (rx_received) begin
            if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
              bus_we <= (rx_byte == CMD_WRITE);
              state  <= GET_ADDR;
            end else begin
              resp      <= {24'h0, RSP_ERR};
              resp_left <= 3'd1;
              state     <= SEND;
            end
          end
        end

        // Priority: framing error, then a received byte, then the inter-byte timeout.
        GET_ADDR, GET_DATA: begin
          if (rx_error) begin
            state <= IDLE;
          end else if (rx_received) begin
            tmo_cnt <= '0;
            if (state == GET_ADDR) begin
              bus_addr <= rx_byte;
              idx      <= '0;
              if (bus_we) begin
                state <= GET_DATA;
              end else begin
                bus_req <= 1'b1;
                state   <= BUS;
              end
            end else begin
              bus_wdata[{idx, 3'b000} +: 8] <= rx_byte;
              idx <= idx + 2'd1;
              if (idx == 2'd3) begin
                bus_req <= 1'b1;
                state   <= BUS;
              end
            end
          end else if (timed_out) begin
            state <= IDLE;
          end else if (tmo_cnt != 16'hFFFF) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_we) begin
              resp      <= {24'h0, RSP_OK};
              resp_left <= 3'd1;
            end else begin
              resp      <= bus_rdata;
              resp_left <= 3'd4;
            end
            state <= SEND;
          end
        end

        // Response bytes leave LSB first; each waits for a full busy high-then-low cycle.
        SEND: begin
          if (!tx_busy) begin
            tx_transmit <= 1'b1;
            tx_data     <= resp[7:0];
            resp        <= {8'h0, resp[31:8]};
            resp_left   <= resp_left - 3'd1;
            state       <= WAIT_HI;
          end
        end

        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
        end

        WAIT_LO: begin
          if (!tx_busy) state <= (resp_left != 3'd0) ? SEND : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - directed self-checking bench for uart_cmd_bridge with UART and bus responders
`timescale 1ns/1ps
module tb_uart_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_received;
  logic [7:0]  rx_byte;
  logic        rx_error;
  logic        tx_busy;
  logic        tx_transmit;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tx_log[$];
  logic        we_log[$];
  logic [7:0]  addr_log[$];
  logic [31:0] wdata_log[$];
  int          tx_viol = 0;
  int          stab_viol = 0;
  int          ack_delay = 3;
  logic [31:0] rdata_val = 32'h0;
  bit          tx_ready = 1'b1;
  int          tx_phase = 0;
  int          bus_wait = 0;

  uart_cmd_bridge #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .rx_received(rx_received), .rx_byte(rx_byte), .rx_error(rx_error),
    .tx_busy(tx_busy), .tx_transmit(tx_transmit), .tx_data(tx_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy rises 2 cycles after a request, stays high 6 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_transmit === 1'b1) begin
        if (!tx_ready) tx_viol++;
        tx_ready = 1'b0;
        tx_log.push_back(tx_data);
        tx_phase = 9;
      end else if (tx_phase > 0) begin
        tx_phase--;
        tx_busy = (tx_phase >= 2 && tx_phase <= 7);
        if (tx_phase == 0) tx_ready = 1'b1;
      end
    end
  end

  // Bus responder: logs each request, checks stability, acks after ack_delay cycles (0 = never).
  initial begin
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req === 1'b1) begin
        if (bus_wait == 0) begin
          we_log.push_back(bus_we);
          addr_log.push_back(bus_addr);
          wdata_log.push_back(bus_wdata);
        end else if (bus_we !== we_log[$] || bus_addr !== addr_log[$] || bus_wdata !== wdata_log[$]) begin
          stab_viol++;
        end
        bus_wait++;
        if (bus_wait == ack_delay) begin
          bus_ack = 1'b1;
          bus_rdata = rdata_val;
          bus_wait = 0;
        end
      end else begin
        bus_wait = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
  endtask

  task automatic send_byte_err(input logic [7:0] b);
    rx_byte = b;
    rx_received = 1'b1;
    rx_error = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic pulse_error();
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    we_log.delete();
    addr_log.delete();
    wdata_log.delete();
  endtask

  task automatic wait_tx(input int n, input string name);
    int cyc = 0;
    while (tx_log.size() < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (tx_log.size() < n) begin
      failures++;
      $display("FAIL %s_tx_wait: got %0d bytes, required %0d", name, tx_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (tx_transmit !== 1'b0) begin failures++; $display("FAIL reset_tx_transmit: got %b required 0", tx_transmit); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req: got %b required 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin failures++; $display("FAIL reset_bus_we: got %b required 0", bus_we); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
    checks++; if (bus_addr !== 8'h00) begin failures++; $display("FAIL reset_bus_addr: got %h required 00", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus_wdata: got %h required 00000000", bus_wdata); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    clear_logs();
    ack_delay = 3;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hEF);
    send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_tx(1, "write");
    idle(30);
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL write_bus_count: got %0d required 1", we_log.size()); end
    if (we_log.size() > 0) begin
      checks++; if (we_log[0] !== 1'b1) begin failures++; $display("FAIL write_we: got %b required 1", we_log[0]); end
      checks++; if (addr_log[0] !== 8'h10) begin failures++; $display("FAIL write_addr: got %h required 10", addr_log[0]); end
      checks++; if (wdata_log[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL write_wdata: got %h required deadbeef", wdata_log[0]); end
    end
    checks++; if (tx_log.size() != 1) begin failures++; $display("FAIL write_tx_count: got %0d required 1", tx_log.size()); end
    if (tx_log.size() > 0) begin
      checks++; if (tx_log[0] !== 8'h4B) begin failures++; $display("FAIL write_tx_byte: got %h required 4b", tx_log[0]); end
    end
  endtask

  task automatic test_read();
    logic [7:0] exp [4];
    logic [7:0] got;
    exp = '{8'h78, 8'h56, 8'h34, 8'h12};
    clear_logs();
    rdata_val = 32'h12345678;
    send_byte(8'h52); send_byte(8'h22);
    wait_tx(4, "read");
    idle(30);
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL read_bus_count: got %0d required 1", we_log.size()); end
    if (we_log.size() > 0) begin
      checks++; if (we_log[0] !== 1'b0) begin failures++; $display("FAIL read_we: got %b required 0", we_log[0]); end
      checks++; if (addr_log[0] !== 8'h22) begin failures++; $display("FAIL read_addr: got %h required 22", addr_log[0]); end
    end
    checks++; if (tx_log.size() != 4) begin failures++; $display("FAIL read_tx_count: got %0d required 4", tx_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL read_tx_byte%0d: got %h required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_bad_cmd_errors();
    logic [7:0] exp [4];
    logic [7:0] got;
    exp = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    clear_logs();
    send_byte(8'h41);
    wait_tx(1, "badcmd");
    idle(20);
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL badcmd_bus_count: got %0d required 0", we_log.size()); end
    checks++; if (tx_log.size() != 1 || tx_log[0] !== 8'h45) begin failures++; $display("FAIL badcmd_tx: got %0d bytes first %h, required 1 byte 45", tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 8'hxx); end

    clear_logs();
    pulse_error();
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hAA);
    pulse_error();
    idle(40);
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL rxerr_write_bus_count: got %0d required 0", we_log.size()); end
    checks++; if (tx_log.size() != 0) begin failures++; $display("FAIL rxerr_write_tx_count: got %0d required 0", tx_log.size()); end

    send_byte(8'h52);
    send_byte_err(8'h05);
    idle(40);
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL rxerr_prio_bus_count: got %0d required 0", we_log.size()); end
    checks++; if (tx_log.size() != 0) begin failures++; $display("FAIL rxerr_prio_tx_count: got %0d required 0", tx_log.size()); end

    rdata_val = 32'hCAFEF00D;
    send_byte(8'h52); send_byte(8'h01);
    wait_tx(4, "after_err");
    idle(30);
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL after_err_bus_count: got %0d required 1", we_log.size()); end
    if (we_log.size() > 0) begin
      checks++; if (addr_log[0] !== 8'h01 || we_log[0] !== 1'b0) begin failures++; $display("FAIL after_err_access: got addr %h we %b required addr 01 we 0", addr_log[0], we_log[0]); end
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL after_err_tx_byte%0d: got %h required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [4];
    logic [7:0] got;
    exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    clear_logs();
    send_byte(8'h52);
    idle(21);
    send_byte(8'h01);
    wait_tx(1, "timeout");
    idle(20);
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL timeout_bus_count: got %0d required 0", we_log.size()); end
    checks++; if (tx_log.size() != 1 || tx_log[0] !== 8'h45) begin failures++; $display("FAIL timeout_tx: got %0d bytes first %h, required 1 byte 45", tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 8'hxx); end

    clear_logs();
    rdata_val = 32'hA1B2C3D4;
    send_byte(8'h52);
    idle(20);
    send_byte(8'h33);
    wait_tx(4, "timeout_edge");
    idle(30);
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL timeout_edge_bus_count: got %0d required 1", we_log.size()); end
    if (addr_log.size() > 0) begin
      checks++; if (addr_log[0] !== 8'h33) begin failures++; $display("FAIL timeout_edge_addr: got %h required 33", addr_log[0]); end
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL timeout_edge_tx_byte%0d: got %h required %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    clear_logs();
    ack_delay = 0;
    send_byte(8'h57); send_byte(8'h44); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    while (bus_req !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rstbus_req_seen: got %b required 1", bus_req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rstbus_req_drop: got %b required 0", bus_req); end
    checks++; if (bus_we !== 1'b0 || bus_addr !== 8'h00 || bus_wdata !== 32'h0) begin failures++; $display("FAIL rstbus_regs: got we %b addr %h wdata %h required 0 00 00000000", bus_we, bus_addr, bus_wdata); end
    rst = 1'b0;
    ack_delay = 3;
    idle(40);
    checks++; if (tx_log.size() != 0) begin failures++; $display("FAIL rstbus_tx_count: got %0d required 0", tx_log.size()); end
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL rstbus_bus_count: got %0d required 1", we_log.size()); end

    clear_logs();
    rdata_val = 32'h11223344;
    send_byte(8'h52); send_byte(8'h07);
    wait_tx(1, "rstresp");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(60);
    checks++; if (tx_log.size() != 1 || tx_log[0] !== 8'h44) begin failures++; $display("FAIL rstresp_tx: got %0d bytes first %h, required 1 byte 44", tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 8'hxx); end
  endtask

  task automatic test_busy_traffic();
    logic [7:0] exp [4];
    logic [7:0] got;
    exp = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
    clear_logs();
    ack_delay = 8;
    rdata_val = 32'h0BADF00D;
    send_byte(8'h52); send_byte(8'h5A); send_byte(8'h41);
    wait_tx(1, "busy_first");
    send_byte(8'h57);
    idle(1);
    send_byte(8'h41);
    pulse_error();
    wait_tx(4, "busy");
    idle(40);
    checks++; if (we_log.size() != 1) begin failures++; $display("FAIL busy_bus_count: got %0d required 1", we_log.size()); end
    checks++; if (tx_log.size() != 4) begin failures++; $display("FAIL busy_tx_count: got %0d required 4", tx_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== exp[i]) begin failures++; $display("FAIL busy_tx_byte%0d: got %h required %h", i, got, exp[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_received = 1'b0;
    rx_byte = 8'h00;
    rx_error = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_bad_cmd_errors();
    test_timeout();
    test_reset_mid_frame();
    test_busy_traffic();
    checks++; if (tx_viol != 0) begin failures++; $display("FAIL tx_handshake: got %0d early transmits required 0", tx_viol); end
    checks++; if (stab_viol != 0) begin failures++; $display("FAIL bus_stability: got %0d unstable cycles required 0", stab_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
